// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master transaction sequencer.
// Holds the phase codes, the latched descriptor and the length clamp.
package spi_master_pkg;

  localparam int MAX_PHASE_BITS = 32;
  localparam int DESC_LEN_W     = 32;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SETUP = 3'd1,
    PH_CMD   = 3'd2,
    PH_ADDR  = 3'd3,
    PH_DUMMY = 3'd4,
    PH_DATA  = 3'd5,
    PH_DRAIN = 3'd6,
    PH_HOLD  = 3'd7
  } phase_e;

  typedef struct packed {
    logic [5:0]            cmd_len;
    logic [5:0]            addr_len;
    logic [5:0]            dummy_len;
    logic [DESC_LEN_W-1:0] data_len;
    logic                  data_rd;
  } spi_desc_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] l);
    return (l > 6'(MAX_PHASE_BITS)) ? 6'(MAX_PHASE_BITS) : l;
  endfunction

endpackage

// File: rtl/spi_master_sequencer_delay.sv
// spi_seq_delay: 4-bit load/expire down-counter for CS setup/hold timing.
// Ports: i_load/i_val preset, i_tick decrements, o_expire when count is 0.
module spi_seq_delay (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_val,
  input  logic       i_tick,
  output logic       o_expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/spi_master_sequencer.sv
// SPI transaction sequencer: walks CS-setup/CMD/ADDR/DUMMY/DATA/CS-hold,
// gates the clkgen, drives csn and the mode-0 shift/sample strobes.
// Ports: req_* descriptor handshake, clk_div*/gen_div* divider forwarding
// (gen_div carries the value paired with gen_div_valid), spi_rise/fall in,
// csn/phase/tx_shift/rx_sample/done out.
module spi_master_sequencer
  import spi_master_pkg::*;
#(
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int LEN_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       cmd_len,
  input  logic [5:0]       addr_len,
  input  logic [5:0]       dummy_len,
  input  logic [LEN_W-1:0] data_len,
  input  logic             data_rd,
  input  logic [7:0]       clk_div,
  input  logic             clk_div_wr,
  output logic             gen_en,
  output logic             gen_div_valid,
  output logic [7:0]       gen_div,
  input  logic             spi_rise,
  input  logic             spi_fall,
  output logic             csn,
  output logic [2:0]       phase,
  output logic             tx_shift,
  output logic             rx_sample,
  output logic             done
);

  phase_e           r_state;
  phase_e           w_next;
  spi_desc_t        r_desc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_csn;
  logic             r_pend;
  logic [7:0]       r_div;

  logic             w_setup_ld;
  logic             w_hold_ld;
  logic             w_setup_exp;
  logic             w_hold_exp;
  logic             w_active;
  logic             w_fall;
  logic             w_last_bit;
  logic [31:0]      w_len;
  phase_e           w_first;
  phase_e           w_after;

  // First phase after cur with a nonzero length, DRAIN if none remain.
  function automatic phase_e next_active(input phase_e cur,
                                         input spi_desc_t d);
    phase_e n;
    n = PH_DRAIN;
    if ((cur < PH_DATA) && (d.data_len != '0))   n = PH_DATA;
    if ((cur < PH_DUMMY) && (d.dummy_len != '0)) n = PH_DUMMY;
    if ((cur < PH_ADDR) && (d.addr_len != '0))   n = PH_ADDR;
    if ((cur < PH_CMD) && (d.cmd_len != '0))     n = PH_CMD;
    return n;
  endfunction

  function automatic logic drives(input phase_e p, input logic rd);
    return (p == PH_CMD) || (p == PH_ADDR) || ((p == PH_DATA) && !rd);
  endfunction

  spi_seq_delay u_setup (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_setup_ld),
    .i_val    (4'(CS_SETUP_CYC - 1)),
    .i_tick   (r_state == PH_SETUP),
    .o_expire (w_setup_exp)
  );

  spi_seq_delay u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_hold_ld),
    .i_val    (4'(CS_HOLD_CYC - 1)),
    .i_tick   (r_state == PH_HOLD),
    .o_expire (w_hold_exp)
  );

  assign w_active = (r_state == PH_CMD) || (r_state == PH_ADDR) ||
                    (r_state == PH_DUMMY) || (r_state == PH_DATA);
  // rise wins if the clkgen ever reports both edges at once
  assign w_fall   = spi_fall && !spi_rise;
  assign w_first  = next_active(PH_SETUP, r_desc);
  assign w_after  = next_active(r_state, r_desc);

  always_comb begin
    w_len = '0;
    unique case (r_state)
      PH_CMD:   w_len = 32'(r_desc.cmd_len);
      PH_ADDR:  w_len = 32'(r_desc.addr_len);
      PH_DUMMY: w_len = 32'(r_desc.dummy_len);
      PH_DATA:  w_len = r_desc.data_len;
      default:  w_len = '0;
    endcase
  end

  assign w_last_bit = (32'(r_cnt) == (w_len - 32'd1));

  always_comb begin
    w_next     = r_state;
    w_setup_ld = 1'b0;
    w_hold_ld  = 1'b0;
    unique case (r_state)
      PH_IDLE: begin
        if (req_valid) begin
          w_next     = PH_SETUP;
          w_setup_ld = 1'b1;
        end
      end
      PH_SETUP: begin
        if (w_setup_exp) begin
          if (w_first == PH_DRAIN) begin
            w_next    = PH_HOLD;
            w_hold_ld = 1'b1;
          end else begin
            w_next = w_first;
          end
        end
      end
      PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA: begin
        if (spi_rise && w_last_bit) w_next = w_after;
      end
      PH_DRAIN: begin
        if (w_fall) begin
          w_next    = PH_HOLD;
          w_hold_ld = 1'b1;
        end
      end
      PH_HOLD: begin
        if (w_hold_exp) w_next = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PH_IDLE;
      r_desc  <= '0;
      r_cnt   <= '0;
      r_csn   <= 1'b1;
      r_pend  <= 1'b0;
      r_div   <= '0;
    end else begin
      r_state <= w_next;
      r_csn   <= (w_next == PH_IDLE);
      if ((r_state == PH_IDLE) && req_valid) begin
        r_desc <= '{cmd_len:   clamp_len(cmd_len),
                    addr_len:  clamp_len(addr_len),
                    dummy_len: clamp_len(dummy_len),
                    data_len:  DESC_LEN_W'(data_len),
                    data_rd:   data_rd};
      end
      if (w_active && spi_rise) begin
        r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
      end
      // divider writes during a transfer wait for IDLE, last one wins
      if (r_state == PH_IDLE) begin
        r_pend <= 1'b0;
      end else if (clk_div_wr) begin
        r_pend <= 1'b1;
        r_div  <= clk_div;
      end
    end
  end

  assign req_ready     = (r_state == PH_IDLE);
  assign gen_en        = w_active;
  assign csn           = r_csn;
  assign phase         = r_state;
  assign gen_div_valid = (r_state == PH_IDLE) && (clk_div_wr || r_pend);
  assign gen_div       = clk_div_wr ? clk_div : r_div;
  assign done          = (r_state == PH_HOLD) && w_hold_exp;
  // extra pulse presents the first MOSI bit before the first rise
  assign tx_shift      = ((r_state == PH_SETUP) && w_setup_exp &&
                          drives(w_first, r_desc.data_rd)) ||
                         (w_fall && drives(r_state, r_desc.data_rd));
  assign rx_sample     = spi_rise && (r_state == PH_DATA) &&
                         r_desc.data_rd;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer.
// Per-cycle trace model built from bit-timeline arithmetic plus literals.
module tb_spi_master_sequencer;

  localparam int LW = 8;
  localparam int S  = 2;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [5:0]    cmd_len = '0;
  logic [5:0]    addr_len = '0;
  logic [5:0]    dummy_len = '0;
  logic [LW-1:0] data_len = '0;
  logic          data_rd = 1'b0;
  logic [7:0]    clk_div = '0;
  logic          clk_div_wr = 1'b0;
  logic          gen_en;
  logic          gen_div_valid;
  logic [7:0]    gen_div;
  logic          spi_rise = 1'b0;
  logic          spi_fall = 1'b0;
  logic          csn;
  logic [2:0]    phase;
  logic          tx_shift;
  logic          rx_sample;
  logic          done;

  always #5 clk = ~clk;

  spi_master_sequencer #(
    .CS_SETUP_CYC (S),
    .CS_HOLD_CYC  (P),
    .LEN_W        (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .cmd_len       (cmd_len),
    .addr_len      (addr_len),
    .dummy_len     (dummy_len),
    .data_len      (data_len),
    .data_rd       (data_rd),
    .clk_div       (clk_div),
    .clk_div_wr    (clk_div_wr),
    .gen_en        (gen_en),
    .gen_div_valid (gen_div_valid),
    .gen_div       (gen_div),
    .spi_rise      (spi_rise),
    .spi_fall      (spi_fall),
    .csn           (csn),
    .phase         (phase),
    .tx_shift      (tx_shift),
    .rx_sample     (rx_sample),
    .done          (done)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic       en;
    logic       tx;
    logic       rx;
    logic       dn;
  } exp_t;

  exp_t       q[$];
  int         H = 1;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         pend_m = 1'b0;
  logic [7:0] pval_m = '0;
  int o_tx, o_rx, o_dn, o_en, o_csl, o_rise, o_gdv;
  logic [7:0] o_div;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic bit drv(input int p, input bit rd);
    return (p == 2) || (p == 3) || ((p == 5) && !rd);
  endfunction

  function automatic int clip(input int l);
    return (l > 32) ? 32 : l;
  endfunction

  // Expected per-cycle trace: accept, setup, 2H cycles per bit, hold.
  // The phase advances right after the rise of a phase's last bit.
  task automatic build(input int c, input int a, input int d,
                       input int n, input bit rd, output int len);
    int   bph[$];
    int   cur;
    int   first;
    int   nb;
    int   base;
    exp_t e;
    base = q.size();
    e = '0;
    q.push_back(e);
    for (int i = 0; i < clip(c); i++) bph.push_back(2);
    for (int i = 0; i < clip(a); i++) bph.push_back(3);
    for (int i = 0; i < clip(d); i++) bph.push_back(4);
    for (int i = 0; i < n; i++)       bph.push_back(5);
    nb = bph.size();
    first = (nb > 0) ? bph[0] : 6;
    for (int i = 0; i < S; i++) begin
      e = '0;
      e.ph = 3'd1;
      e.tx = (i == S - 1) && drv(first, rd);
      q.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      for (int o = 0; o < 2 * H; o++) begin
        cur = (o < H) ? bph[b] : ((b + 1 < nb) ? bph[b + 1] : 6);
        e = '0;
        e.ph = 3'(cur);
        e.en = (cur >= 2) && (cur <= 5);
        e.rx = (o == H - 1) && (bph[b] == 5) && rd;
        e.tx = (o == 2 * H - 1) && drv(cur, rd);
        q.push_back(e);
      end
    end
    for (int i = 0; i < P; i++) begin
      e = '0;
      e.ph = 3'd7;
      e.dn = (i == P - 1);
      q.push_back(e);
    end
    len = q.size() - base;
  endtask

  // clock generator stand-in: H cycles low, H high, stops low when disabled
  initial begin
    bit sclk;
    int cnt;
    sclk = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      spi_rise = 1'b0;
      spi_fall = 1'b0;
      if (rst) begin
        sclk = 1'b0;
        cnt = 0;
      end else if (!sclk) begin
        if (gen_en) begin
          cnt++;
          if (cnt == H) begin
            spi_rise = 1'b1;
            sclk = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == H) begin
          spi_fall = 1'b1;
          sclk = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // compare process: one trace entry per cycle, idle when trace empty
  initial begin
    exp_t       e;
    bit         gv;
    logic [7:0] dv;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      e = (q.size() > 0) ? q.pop_front() : '0;
      chk("outputs",
          {phase, csn, req_ready, gen_en, tx_shift, rx_sample, done},
          {e.ph, e.ph == 3'd0, e.ph == 3'd0, e.en, e.tx, e.rx, e.dn});
      if (e.ph == 3'd0) begin
        gv = clk_div_wr || pend_m;
        dv = clk_div_wr ? clk_div : pval_m;
        chk("div_valid", gen_div_valid, gv);
        if (gv) chk("div_value", gen_div, dv);
        pend_m = 1'b0;
      end else begin
        if (clk_div_wr) begin
          pend_m = 1'b1;
          pval_m = clk_div;
        end
        chk("div_valid_busy", gen_div_valid, 0);
      end
      o_tx   += int'(tx_shift);
      o_rx   += int'(rx_sample);
      o_dn   += int'(done);
      o_en   += int'(gen_en);
      o_csl  += int'(!csn);
      o_rise += int'(spi_rise);
      if (gen_div_valid) begin
        o_gdv++;
        o_div = gen_div;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    o_tx = 0; o_rx = 0; o_dn = 0; o_en = 0;
    o_csl = 0; o_rise = 0; o_gdv = 0; o_div = '0;
  endtask

  task automatic wait_q(input int lim, input string nm);
    int k;
    k = 0;
    while (q.size() > lim && k < 3000) begin
      tick();
      k++;
    end
    if (q.size() > lim) begin
      chk({nm, "_timeout"}, q.size(), lim);
      q.delete();
    end
  endtask

  task automatic set_desc(input int c, input int a, input int d,
                          input int n, input bit rd);
    cmd_len   = 6'(c);
    addr_len  = 6'(a);
    dummy_len = 6'(d);
    data_len  = LW'(n);
    data_rd   = rd;
  endtask

  task automatic start(input int c, input int a, input int d,
                       input int n, input bit rd);
    int len;
    set_desc(c, a, d, n, rd);
    build(c, a, d, n, rd, len);
    req_valid = 1'b1;
    wait_q(len - 1, "accept");
    req_valid = 1'b0;
  endtask

  task automatic finish();
    wait_q(0, "complete");
    tick();
    tick();
  endtask

  task automatic go(input int c, input int a, input int d,
                    input int n, input bit rd);
    start(c, a, d, n, rd);
    finish();
  endtask

  initial begin
    int k;
    int l1;
    int l2;
    clr();
    tick();
    tick();
    chk("rst_csn", csn, 1);
    chk("rst_gen_en", gen_en, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_phase", phase, 0);
    chk("rst_strobes", {tx_shift, rx_sample, done, gen_div_valid}, 0);
    rst = 1'b0;
    tick();

    // full frame, read data
    clr();
    go(8, 24, 8, 32, 1);
    chk("full_tx", o_tx, 32);
    chk("full_rx", o_rx, 32);
    chk("full_done", o_dn, 1);
    chk("full_rise", o_rise, 72);

    // command only
    clr();
    go(8, 0, 0, 0, 0);
    chk("cmd_rise", o_rise, 8);
    chk("cmd_tx", o_tx, 8);
    chk("cmd_csn_low", o_csl, 20);

    // all lengths zero: CS pulse only
    clr();
    go(0, 0, 0, 0, 0);
    chk("zero_gen_en", o_en, 0);
    chk("zero_csn_low", o_csl, 4);
    chk("zero_done", o_dn, 1);
    chk("zero_tx", o_tx, 0);

    // divider writes during ADDR are deferred, last one wins
    clr();
    start(8, 24, 0, 4, 0);
    k = 0;
    while (phase != 3'd3 && k < 500) begin
      tick();
      k++;
    end
    clk_div = 8'd9;
    clk_div_wr = 1'b1;
    tick();
    clk_div = 8'd3;
    tick();
    clk_div_wr = 1'b0;
    finish();
    chk("div_pulses", o_gdv, 1);
    chk("div_val", o_div, 3);
    clk_div = 8'd5;
    clk_div_wr = 1'b1;
    tick();
    clk_div_wr = 1'b0;
    tick();
    chk("div_idle_pulses", o_gdv, 2);
    chk("div_idle_val", o_div, 5);

    // oversize command length clamps to 32
    clr();
    go(63, 0, 0, 0, 0);
    chk("clamp_rise", o_rise, 32);
    chk("clamp_tx", o_tx, 32);

    // back-to-back with req_valid held high
    clr();
    set_desc(0, 0, 0, 1, 0);
    build(0, 0, 0, 1, 0, l1);
    build(0, 0, 0, 1, 0, l2);
    req_valid = 1'b1;
    wait_q(l2 - 1, "b2b_accept");
    req_valid = 1'b0;
    finish();
    chk("b2b_tx", o_tx, 2);
    chk("b2b_done", o_dn, 2);
    chk("b2b_rise", o_rise, 2);

    // slower SPI clock, dummy between cmd and write data
    H = 2;
    clr();
    go(4, 0, 2, 3, 0);
    chk("slow_tx", o_tx, 7);
    chk("slow_rise", o_rise, 9);
    H = 1;

    // maximum data length, no counter wrap
    clr();
    go(0, 0, 0, 255, 0);
    chk("max_tx", o_tx, 255);
    chk("max_rise", o_rise, 255);
    chk("max_done", o_dn, 1);

    // reset during data bit 5, with a divider write pending
    clr();
    start(0, 0, 0, 16, 1);
    k = 0;
    while (o_rx < 5 && k < 500) begin
      tick();
      k++;
    end
    clk_div = 8'd6;
    clk_div_wr = 1'b1;
    tick();
    clk_div_wr = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    pend_m = 1'b0;
    #1;
    chk("midrst_csn", csn, 1);
    chk("midrst_gen_en", gen_en, 0);
    chk("midrst_phase", phase, 0);
    tick();
    rst = 1'b0;
    clr();
    tick();
    tick();
    chk("midrst_no_div", o_gdv, 0);
    clr();
    go(8, 0, 0, 0, 0);
    chk("post_rst_done", o_dn, 1);
    chk("post_rst_rise", o_rise, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far",
             n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
